// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer and the traffic-light controller:
// interval select codes, default durations, the countdown state type and a
// helper that folds the reserved interval code onto the base interval.
package interval_timer_pkg;

    // Duration select codes; 2'b11 is reserved and behaves as base.
    typedef enum logic [1:0] {
        BASE_ADD = 2'b00,
        EXT_ADD  = 2'b01,
        YEL_ADD  = 2'b10,
        RSVD_ADD = 2'b11
    } interval_code_t;

    // Default durations in seconds (reset values and zero-substitutes).
    localparam int BASE_DEFAULT_S = 6;
    localparam int EXT_DEFAULT_S  = 3;
    localparam int YEL_DEFAULT_S  = 2;

    // Number of programmable duration registers.
    localparam int NUM_PARAMS = 3;

    // Countdown state: idle or counting.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } timer_state_t;

    // Map the reserved code onto base so the selector only sees 00/01/10.
    function automatic logic [1:0] effective_interval(input logic [1:0] code);
        logic [1:0] result;
        result = code;
        if (code == 2'(RSVD_ADD)) begin
            result = 2'(BASE_ADD);
        end
        return result;
    endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Bundle of control, programming and status signals between the controller
// side (master) and the interval timer (slave).
interface interval_timer_if #(
    parameter int WIDTH = 4
);
    logic             one_hz_enable;
    logic             start_timer;
    logic [1:0]       interval;
    logic             prog_write;
    logic [1:0]       param_sel;
    logic [WIDTH-1:0] time_value;
    logic             expired;
    logic [WIDTH-1:0] remaining;
    logic             running;

    modport master (
        output one_hz_enable,
        output start_timer,
        output interval,
        output prog_write,
        output param_sel,
        output time_value,
        input  expired,
        input  remaining,
        input  running
    );

    modport slave (
        input  one_hz_enable,
        input  start_timer,
        input  interval,
        input  prog_write,
        input  param_sel,
        input  time_value,
        output expired,
        output remaining,
        output running
    );
endinterface

// File: rtl/interval_timer_time_param_regs.sv
// Three programmable duration registers (base, extended, yellow) with
// zero-to-default substitution on write, plus a selector that returns the
// duration for the requested interval, forwarding a same-edge write.
module time_param_regs
    import interval_timer_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int BASE_DEFAULT = BASE_DEFAULT_S,
    parameter int EXT_DEFAULT  = EXT_DEFAULT_S,
    parameter int YEL_DEFAULT  = YEL_DEFAULT_S
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_write,
    input  logic [1:0]       param_sel,
    input  logic [WIDTH-1:0] time_value,
    input  logic [1:0]       interval,
    output logic [WIDTH-1:0] sel_value
);

    logic [WIDTH-1:0] param_value [NUM_PARAMS];
    logic [WIDTH-1:0] write_value [NUM_PARAMS];
    logic [1:0]       eff_sel;
    logic             bypass;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
            localparam int DEF_INT = (gi == 0) ? BASE_DEFAULT :
                                     (gi == 1) ? EXT_DEFAULT  : YEL_DEFAULT;
            localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_INT);

            logic [WIDTH-1:0] value_reg;

            // A zero duration is meaningless, so it falls back to the default.
            assign write_value[gi] = (time_value == '0) ? DEF : time_value;
            assign param_value[gi] = value_reg;

            // Duration register: reset to default, written when selected.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    value_reg <= DEF;
                end else if (prog_write && (param_sel == 2'(gi))) begin
                    value_reg <= write_value[gi];
                end
            end
        end
    endgenerate

    assign eff_sel = effective_interval(interval);
    assign bypass  = prog_write && (param_sel == eff_sel);

    // Select the requested duration; a coincident write to it wins.
    always_comb begin
        sel_value = param_value[0];
        case (eff_sel)
            2'(EXT_ADD): sel_value = bypass ? write_value[1] : param_value[1];
            2'(YEL_ADD): sel_value = bypass ? write_value[2] : param_value[2];
            default:     sel_value = bypass ? write_value[0] : param_value[0];
        endcase
    end

endmodule

// File: rtl/interval_timer.sv
// Countdown timer feeding the traffic-light controller. Loads the selected
// duration on start_timer, decrements once per one_hz_enable tick and emits
// a single-cycle expired pulse when the count reaches zero.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int BASE_DEFAULT = BASE_DEFAULT_S,
    parameter int EXT_DEFAULT  = EXT_DEFAULT_S,
    parameter int YEL_DEFAULT  = YEL_DEFAULT_S
) (
    input  logic              clk,
    input  logic              rst,
    interval_timer_if.slave   bus
);

    timer_state_t     state_reg;
    logic [WIDTH-1:0] remaining_reg;
    logic             expired_reg;
    logic [WIDTH-1:0] sel_value;

    time_param_regs #(
        .WIDTH        (WIDTH),
        .BASE_DEFAULT (BASE_DEFAULT),
        .EXT_DEFAULT  (EXT_DEFAULT),
        .YEL_DEFAULT  (YEL_DEFAULT)
    ) u_params (
        .clk        (clk),
        .rst        (rst),
        .prog_write (bus.prog_write),
        .param_sel  (bus.param_sel),
        .time_value (bus.time_value),
        .interval   (bus.interval),
        .sel_value  (sel_value)
    );

    // Countdown FSM: start restarts unconditionally and swallows a coincident
    // tick; the final tick clears the counter and raises expired for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            expired_reg   <= 1'b0;
        end else begin
            expired_reg <= 1'b0;
            if (bus.start_timer) begin
                remaining_reg <= sel_value;
                state_reg     <= ST_COUNT;
            end else if ((state_reg == ST_COUNT) && bus.one_hz_enable) begin
                if (remaining_reg > WIDTH'(1)) begin
                    remaining_reg <= remaining_reg - WIDTH'(1);
                end else begin
                    remaining_reg <= '0;
                    state_reg     <= ST_IDLE;
                    expired_reg   <= 1'b1;
                end
            end
        end
    end

    assign bus.remaining = remaining_reg;
    assign bus.running   = (state_reg == ST_COUNT);
    assign bus.expired   = expired_reg;

endmodule

// File: tb/tb_interval_timer.sv
// Directed, table-driven bench for interval_timer with hand-written
// sequences for the asynchronous reset and post-reset countdown.
module tb_interval_timer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    interval_timer_if #(.WIDTH(4)) bus ();

    interval_timer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [1:0] iv;
        logic       pw;
        logic [1:0] ps;
        logic [3:0] tv;
        logic       tk;
        logic [3:0] rem;
        logic       run;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [1:0] iv, input logic pw,
                       input logic [1:0] ps, input logic [3:0] tv, input logic tk,
                       input logic [3:0] rem, input logic run, input logic exp);
        vec_t v;
        v.st = st; v.iv = iv; v.pw = pw; v.ps = ps; v.tv = tv; v.tk = tk;
        v.rem = rem; v.run = run; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, got, want);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [3:0] rem,
                                 input logic run, input logic exp);
        $display("step %0d: remaining=%0d running=%0b expired=%0b (want %0d/%0b/%0b)",
                 idx, bus.remaining, bus.running, bus.expired, rem, run, exp);
        check("remaining", idx, 32'(bus.remaining), 32'(rem));
        check("running",   idx, 32'(bus.running),   32'(run));
        check("expired",   idx, 32'(bus.expired),   32'(exp));
    endtask

    // Drive one cycle of inputs at the falling edge, settle just after the rise.
    task automatic drive(input logic st, input logic [1:0] iv, input logic pw,
                         input logic [1:0] ps, input logic [3:0] tv, input logic tk);
        @(negedge clk);
        bus.start_timer   = st;
        bus.interval      = iv;
        bus.prog_write    = pw;
        bus.param_sel     = ps;
        bus.time_value    = tv;
        bus.one_hz_enable = tk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.start_timer   = 1'b0;
        bus.interval      = 2'b00;
        bus.prog_write    = 1'b0;
        bus.param_sel     = 2'b00;
        bus.time_value    = 4'd0;
        bus.one_hz_enable = 1'b0;

        // ---- vector table: st iv pw ps tv tk | rem run exp ----
        // Base countdown of 6 with a tick-less hold in the middle.
        add(1, 2'd0, 0, 2'd0, 4'd0, 0,  4'd6, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd5, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 0,  4'd5, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd4, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd3, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd2, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd1, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd0, 0, 1);
        add(0, 2'd0, 0, 2'd0, 4'd0, 0,  4'd0, 0, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd0, 0, 0);
        // Yellow written with 0 -> default 2.
        add(0, 2'd0, 1, 2'd2, 4'd0, 0,  4'd0, 0, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 0,  4'd2, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd1, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd0, 0, 1);
        // Yellow written with 9 -> 9-tick countdown.
        add(0, 2'd0, 1, 2'd2, 4'd9, 0,  4'd0, 0, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 0,  4'd9, 1, 0);
        for (int r = 8; r >= 1; r--) add(0, 2'd0, 0, 2'd0, 4'd0, 1, 4'(r), 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd0, 0, 1);
        // Same-edge write to the selected register is forwarded (base=4).
        add(1, 2'd0, 1, 2'd0, 4'd4, 0,  4'd4, 1, 0);
        // Restore base to 6 while running.
        add(0, 2'd0, 1, 2'd0, 4'd0, 0,  4'd4, 1, 0);
        // Write to ext while loading base: old base 6 is used, ext becomes 4.
        add(1, 2'd0, 1, 2'd1, 4'd4, 0,  4'd6, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd5, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd4, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd3, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd2, 1, 0);
        // Restore ext to default 3, then restart at remaining=2.
        add(0, 2'd0, 1, 2'd1, 4'd0, 0,  4'd2, 1, 0);
        add(1, 2'd1, 0, 2'd0, 4'd0, 0,  4'd3, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd2, 1, 0);
        // Start coincident with a tick: full value, tick discarded.
        add(1, 2'd1, 0, 2'd0, 4'd0, 1,  4'd3, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd2, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd1, 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd0, 0, 1);
        // interval=11 loads base; param_sel=11 write changes nothing.
        add(1, 2'd3, 1, 2'd3, 4'd5, 0,  4'd6, 1, 0);
        for (int r = 5; r >= 1; r--) add(0, 2'd0, 0, 2'd0, 4'd0, 1, 4'(r), 1, 0);
        add(0, 2'd0, 0, 2'd0, 4'd0, 1,  4'd0, 0, 1);
        add(1, 2'd1, 0, 2'd0, 4'd0, 0,  4'd3, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 0,  4'd9, 1, 0);
        // Program base=9 with bypass, count down to 3 for the reset test.
        add(1, 2'd0, 1, 2'd0, 4'd9, 0,  4'd9, 1, 0);
        for (int r = 8; r >= 3; r--) add(0, 2'd0, 0, 2'd0, 4'd0, 1, 4'(r), 1, 0);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---- table ----
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].iv, vecs[i].pw, vecs[i].ps, vecs[i].tv, vecs[i].tk);
            check_outputs(i, vecs[i].rem, vecs[i].run, vecs[i].exp);
        end

        // ---- asynchronous reset mid-count (remaining=3) ----
        @(negedge clk);
        bus.one_hz_enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outputs(1000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Idle ticks after reset: nothing happens, no stale pulse.
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 0, 2'd0, 4'd0, 1);
            check_outputs(1001 + i, 4'd0, 1'b0, 1'b0);
        end
        // Base is back to its default 6.
        drive(1, 2'd0, 0, 2'd0, 4'd0, 0);
        check_outputs(1010, 4'd6, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 2'd0, 0, 2'd0, 4'd0, 1);
            check_outputs(1010 + i, 4'(6 - i), (i != 6), (i == 6));
        end
        // Pulse lasts exactly one cycle.
        drive(0, 2'd0, 0, 2'd0, 4'd0, 0);
        check_outputs(1020, 4'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Countdown timer stage directly downstream of the traffic-light controller FSM. It consumes that FSM's start_timer and interval[1:0] outputs and produces the expired pulse the FSM branches on.
- Holds three programmable duration registers: base, extended and yellow. Counts down the selected duration in 1 Hz ticks from the upstream clock divider.
- Sits between the synchronised programming inputs and the controller FSM.

Parameters:
- WIDTH, 4, bit width of duration registers, time_value and the counter.
- BASE_DEFAULT, 6, base interval in seconds (reset value and zero-substitute).
- EXT_DEFAULT, 3, extended interval in seconds (reset value and zero-substitute).
- YEL_DEFAULT, 2, yellow interval in seconds (reset value and zero-substitute).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- Reset  input  1  asynchronous, active-high reset.
- one_hz_enable  input  1  single-clk-cycle tick, once per second, from the divider.
- start_timer  input  1  load the counter with the selected duration and begin counting.
- interval  input  2  duration select: 00 base, 01 extended, 10 yellow, 11 treated as base.
- prog_write  input  1  synchronised programming strobe (Prog_Sync).
- param_sel  input  2  register to program: 00 base, 01 extended, 10 yellow, 11 no write.
- time_value  input  WIDTH  new duration in seconds.
- expired  output  1  one-clk pulse when the loaded duration has elapsed.
- remaining  output  WIDTH  current counter value, for the display.
- running  output  1  high while a countdown is in progress.

Behaviour:
- Reset (async assert, any time, including mid-count):
  - base/ext/yel = their defaults.
  - remaining = 0, running = 0, expired = 0.
- Programming, on a posedge with prog_write = 1:
  - reg[param_sel] <= time_value; if time_value == 0, load that register's default instead.
  - param_sel = 11: no register changes.
  - prog_write = 0: all registers hold.
- Load, on a posedge with start_timer = 1:
  - remaining <= selected duration; running <= 1; expired <= 0.
  - Bypass: if prog_write is also 1 and param_sel equals the effective interval (11 maps to 00), the load uses the new written value, with zero substituted by the default. Otherwise it uses the register value before the write.
  - start_timer while running restarts the count. No expired pulse is produced for the aborted count.
  - start_timer takes priority over a coincident one_hz_enable; that tick is discarded.
- Count, on a posedge with running = 1, start_timer = 0 and one_hz_enable = 1:
  - remaining > 1: remaining decrements by 1.
  - remaining == 1: remaining <= 0, running <= 0, expired <= 1.
- expired:
  - Registered; high for exactly one clk cycle, then returns to 0 on the next posedge.
  - Not re-asserted while idle.
  - Latency: a duration T yields expired exactly at the T-th tick edge after the load edge.
- Idle (running = 0): ticks are ignored and remaining holds 0.
- Arithmetic: unsigned WIDTH bits; the counter never underflows past 0. Maximum duration is 2^WIDTH-1 (15 s at the default width).

Decomposition:
- Shared package holds:
  - interval codes BASE_ADD = 2'b00, EXT_ADD = 2'b01, YEL_ADD = 2'b10; code 2'b11 is reserved.
  - the default durations.
  - The controller FSM imports the same codes.
- One sub-module: time_param_regs. It holds the three registers, the zero-default substitution and the write path, and exposes the selected value with bypass. The countdown logic stays in interval_timer.

Test Plan:
- Reset, then start_timer with interval = 00 and 6 ticks: remaining goes 6,5,4,3,2,1,0; expired is a single cycle on the 6th tick edge; running then drops to 0.
- prog_write with param_sel = 10, time_value = 0; then start with interval = 10: loads 2 (default). Repeat with time_value = 9: loads 9 and expires after 9 ticks.
- start_timer, prog_write = 1, param_sel = 00, time_value = 4, interval = 00 all on the same edge: remaining = 4 (bypass). Same with param_sel = 01: remaining = old base of 6, and ext becomes 4.
- Restart at remaining = 2 with interval = 01: remaining = 3, no expired pulse. start_timer coinciding with a tick: remaining = full value, not decremented.
- Reset asserted asynchronously mid-count at remaining = 3 with a programmed base of 9: outputs clear immediately without a clock edge. Base returns to 6 and expired never pulses.
- interval = 11 and param_sel = 11 write: loads base; no register changes; ticks while idle leave remaining = 0 and expired = 0.
